// File: rtl/dac_sync_mon_pkg.sv
// Shared types and constants for the DAC SYNC~ monitor.
// Optional build macro DAC_SYNC_FILTER_EN (see dac_sync_lane) is not referenced here.
package dac_sync_mon_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOCK = 2'd1,
        LOCKED    = 2'd2,
        LOST      = 2'd3
    } lane_state_t;

    localparam int unsigned      CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_SAT = 8'd255;

    localparam int unsigned LOCK_CYCLES_DEF    = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1_000_000;
    localparam int unsigned FILTER_LEN_DEF     = 4;

endpackage

// File: rtl/dac_sync_lane.sv
// One SYNC~ lane: input synchronizer, lock FSM, lock/timeout counters and saturating loss count.
// Build macro DAC_SYNC_FILTER_EN requires FILTER_LEN consecutive low samples before a loss.
module dac_sync_lane
    import dac_sync_mon_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES    = LOCK_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned FILTER_LEN     = FILTER_LEN_DEF
) (
    input  logic             clk_50m_bufg,
    input  logic             rst_glb,
    input  logic             sync_raw,
    input  logic             rdy_s,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             link_up,
    output logic             lose_pulse,
    output logic             lock_timeout
);

    localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          sync_meta;
    logic          sync_s;
    lane_state_t   state;
    lane_state_t   next_state;
    logic [LW-1:0] lock_cnt;
    logic [TW-1:0] to_cnt;
    logic          to_hit;
    logic          loss;

    always_ff @(posedge clk_50m_bufg or posedge rst_glb) begin
        if (rst_glb) begin
            sync_meta <= 1'b0;
            sync_s    <= 1'b0;
        end else begin
            sync_meta <= sync_raw;
            sync_s    <= sync_meta;
        end
    end

`ifdef DAC_SYNC_FILTER_EN
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    logic [FW-1:0] low_run;

    // Run length of low samples seen while LOCKED; any high sample restarts it.
    always_ff @(posedge clk_50m_bufg or posedge rst_glb) begin
        if (rst_glb) begin
            low_run <= '0;
        end else if (state == LOCKED && !sync_s) begin
            low_run <= low_run + 1'b1;
        end else begin
            low_run <= '0;
        end
    end

    assign loss = !sync_s && (low_run == FW'(FILTER_LEN - 1));
`else
    logic filter_len_unused;
    assign filter_len_unused = ^FILTER_LEN;
    assign loss = !sync_s;
`endif

    always_ff @(posedge clk_50m_bufg or posedge rst_glb) begin
        if (rst_glb) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (!rdy_s) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:      next_state = WAIT_LOCK;
                WAIT_LOCK: if (sync_s && lock_cnt == LW'(LOCK_CYCLES - 1)) next_state = LOCKED;
                LOCKED:    if (loss) next_state = LOST;
                LOST:      next_state = WAIT_LOCK;
                default:   next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        link_up    = (state == LOCKED);
        lose_pulse = (state == LOST);
    end

    assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_50m_bufg or posedge rst_glb) begin
        if (rst_glb) begin
            lock_cnt <= '0;
            to_cnt   <= '0;
        end else if (state == WAIT_LOCK) begin
            lock_cnt <= sync_s ? lock_cnt + 1'b1 : '0;
            to_cnt   <= to_hit ? '0 : to_cnt + 1'b1;
        end else begin
            lock_cnt <= '0;
            to_cnt   <= '0;
        end
    end

    // Clear outranks both the sticky set and the increment; rdy_s low freezes both.
    always_ff @(posedge clk_50m_bufg or posedge rst_glb) begin
        if (rst_glb) begin
            lock_timeout <= 1'b0;
            cnt          <= '0;
        end else if (clr) begin
            lock_timeout <= 1'b0;
            cnt          <= '0;
        end else if (rdy_s) begin
            if (state == WAIT_LOCK && to_hit) begin
                lock_timeout <= 1'b1;
            end
            if (state == LOST && cnt != CNT_SAT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_sync_monitor.sv
// Two-lane JESD204B SYNC~ monitor: adda_ready synchronizer, session-start detect, lane instances.
// Build macro DAC_SYNC_FILTER_EN enables the per-lane low-run loss filter.
module dac_sync_monitor
    import dac_sync_mon_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES    = LOCK_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned FILTER_LEN     = FILTER_LEN_DEF
) (
    input  logic             clk_50m_bufg,
    input  logic             rst_glb,
    input  logic [1:0]       dac_sync,
    input  logic             adda_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] dac0_cnt_lose_sync,
    output logic [CNT_W-1:0] dac1_cnt_lose_sync,
    output logic [1:0]       link_up,
    output logic             all_link_up,
    output logic [1:0]       lose_sync_pulse,
    output logic [1:0]       lock_timeout
);

    logic rdy_meta;
    logic rdy_s;
    logic rdy_prev;
    logic clr;

    always_ff @(posedge clk_50m_bufg or posedge rst_glb) begin
        if (rst_glb) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
            rdy_prev <= 1'b0;
        end else begin
            rdy_meta <= adda_ready;
            rdy_s    <= rdy_meta;
            rdy_prev <= rdy_s;
        end
    end

    // A fresh rdy_s rising edge opens a new session, same effect as cnt_clr.
    assign clr = cnt_clr | (rdy_s & ~rdy_prev);

    dac_sync_lane #(
        .LOCK_CYCLES    (LOCK_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FILTER_LEN     (FILTER_LEN)
    ) u_lane0 (
        .clk_50m_bufg (clk_50m_bufg),
        .rst_glb      (rst_glb),
        .sync_raw     (dac_sync[0]),
        .rdy_s        (rdy_s),
        .clr          (clr),
        .cnt          (dac0_cnt_lose_sync),
        .link_up      (link_up[0]),
        .lose_pulse   (lose_sync_pulse[0]),
        .lock_timeout (lock_timeout[0])
    );

    dac_sync_lane #(
        .LOCK_CYCLES    (LOCK_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FILTER_LEN     (FILTER_LEN)
    ) u_lane1 (
        .clk_50m_bufg (clk_50m_bufg),
        .rst_glb      (rst_glb),
        .sync_raw     (dac_sync[1]),
        .rdy_s        (rdy_s),
        .clr          (clr),
        .cnt          (dac1_cnt_lose_sync),
        .link_up      (link_up[1]),
        .lose_pulse   (lose_sync_pulse[1]),
        .lock_timeout (lock_timeout[1])
    );

    assign all_link_up = &link_up;

endmodule

// File: tb/tb_dac_sync_monitor.sv
// Directed self-checking bench for dac_sync_monitor (TIMEOUT_CYCLES reduced to 100).
// Expectations adapt to builds with DAC_SYNC_FILTER_EN defined (FILTER_LEN = 4).
module tb_dac_sync_monitor;

    localparam int unsigned LOCK = 16;
    localparam int unsigned TOUT = 100;
`ifdef DAC_SYNC_FILTER_EN
    localparam int F = 4;
`else
    localparam int F = 1;
`endif
    localparam int GLITCH_EXP = (F <= 3) ? 1 : 0;

    logic       clk_50m_bufg = 1'b0;
    logic       rst_glb;
    logic [1:0] dac_sync;
    logic       adda_ready;
    logic       cnt_clr;
    logic [7:0] dac0_cnt_lose_sync;
    logic [7:0] dac1_cnt_lose_sync;
    logic [1:0] link_up;
    logic       all_link_up;
    logic [1:0] lose_sync_pulse;
    logic [1:0] lock_timeout;

    int checks = 0;
    int errors = 0;

    dac_sync_monitor #(
        .LOCK_CYCLES    (LOCK),
        .TIMEOUT_CYCLES (TOUT),
        .FILTER_LEN     (4)
    ) dut (
        .clk_50m_bufg       (clk_50m_bufg),
        .rst_glb            (rst_glb),
        .dac_sync           (dac_sync),
        .adda_ready         (adda_ready),
        .cnt_clr            (cnt_clr),
        .dac0_cnt_lose_sync (dac0_cnt_lose_sync),
        .dac1_cnt_lose_sync (dac1_cnt_lose_sync),
        .link_up            (link_up),
        .all_link_up        (all_link_up),
        .lose_sync_pulse    (lose_sync_pulse),
        .lock_timeout       (lock_timeout)
    );

    always #10 clk_50m_bufg = ~clk_50m_bufg;

    task automatic tick();
        @(posedge clk_50m_bufg);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_link(input logic [1:0] mask, input int budget, input string tag);
        int n = 0;
        while (link_up !== mask && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(link_up), 32'(mask));
    endtask

    task automatic lose_lane0(output int pulses);
        pulses = 0;
        dac_sync[0] = 1'b0;
        repeat (F + 4) begin
            tick();
            if (lose_sync_pulse[0] === 1'b1) pulses++;
        end
        dac_sync[0] = 1'b1;
        wait_link(2'b11, 30, "relock0");
    endtask

    initial begin
        int p;
        int total;

        rst_glb    = 1'b1;
        dac_sync   = 2'b11;
        adda_ready = 1'b0;
        cnt_clr    = 1'b0;
        repeat (3) tick();
        chk("rst_cnt0", 32'(dac0_cnt_lose_sync), 0);
        chk("rst_cnt1", 32'(dac1_cnt_lose_sync), 0);
        chk("rst_flags", {link_up, all_link_up, lose_sync_pulse, lock_timeout}, 0);
        rst_glb = 1'b0;
        repeat (2) tick();

        // Initial lock of both lanes.
        adda_ready = 1'b1;
        repeat (LOCK) tick();
        chk("early_lock", 32'(link_up), 0);
        wait_link(2'b11, 4, "first_lock");
        chk("all_link_up", 32'(all_link_up), 1);
        chk("lock_cnt0", 32'(dac0_cnt_lose_sync), 0);
        chk("lock_cnt1", 32'(dac1_cnt_lose_sync), 0);

        // Lane 0 dropped for 10 cycles: exact loss latency.
        dac_sync[0] = 1'b0;
        repeat (F + 1) tick();
        chk("pre_lost_pulse", 32'(lose_sync_pulse), 0);
        chk("pre_lost_link", 32'(link_up), 2'b11);
        tick();
        chk("lost_pulse", 32'(lose_sync_pulse), 2'b01);
        chk("lost_cnt_old", 32'(dac0_cnt_lose_sync), 0);
        chk("lost_link", 32'(link_up), 2'b10);
        tick();
        chk("post_lost_pulse", 32'(lose_sync_pulse), 0);
        chk("post_lost_cnt", 32'(dac0_cnt_lose_sync), 1);
        repeat (10 - (F + 3)) tick();
        dac_sync[0] = 1'b1;
        wait_link(2'b11, 30, "relock_a");
        chk("drop_cnt0", 32'(dac0_cnt_lose_sync), 1);
        chk("drop_cnt1", 32'(dac1_cnt_lose_sync), 0);

        // Short and long lows on lane 1.
        dac_sync[1] = 1'b0;
        repeat (3) tick();
        dac_sync[1] = 1'b1;
        repeat (8) tick();
        wait_link(2'b11, 30, "relock_glitch");
        chk("glitch_cnt1", 32'(dac1_cnt_lose_sync), 32'(GLITCH_EXP));
        dac_sync[1] = 1'b0;
        repeat (6) tick();
        dac_sync[1] = 1'b1;
        repeat (4) tick();
        wait_link(2'b11, 30, "relock_long");
        chk("long_cnt1", 32'(dac1_cnt_lose_sync), 32'(GLITCH_EXP + 1));

        // Saturation over 300 losses on lane 0.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_cnt0", 32'(dac0_cnt_lose_sync), 0);
        chk("clr_cnt1", 32'(dac1_cnt_lose_sync), 0);
        total = 0;
        for (int ev = 1; ev <= 300; ev++) begin
            lose_lane0(p);
            total += p;
            if (ev == 254) chk("cnt_254", 32'(dac0_cnt_lose_sync), 254);
            if (ev == 255) chk("cnt_255", 32'(dac0_cnt_lose_sync), 255);
        end
        chk("sat_cnt0", 32'(dac0_cnt_lose_sync), 255);
        chk("sat_pulses", 32'(total), 300);
        chk("sat_cnt1", 32'(dac1_cnt_lose_sync), 0);

        // Lane 1 held low until lock timeout.
        dac_sync[1] = 1'b0;
        repeat (102 + F) tick();
        chk("timeout_early", 32'(lock_timeout), 0);
        tick();
        chk("timeout_set", 32'(lock_timeout), 2'b10);
        chk("timeout_cnt1", 32'(dac1_cnt_lose_sync), 1);
        repeat (5) tick();
        chk("timeout_sticky", 32'(lock_timeout), 2'b10);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_timeout", 32'(lock_timeout), 0);
        chk("clr_cnt0_b", 32'(dac0_cnt_lose_sync), 0);
        chk("clr_cnt1_b", 32'(dac1_cnt_lose_sync), 0);
        dac_sync[1] = 1'b1;
        wait_link(2'b11, 30, "relock_b");

        // Clear coincident with LOST.
        lose_lane0(p);
        chk("one_loss", 32'(dac0_cnt_lose_sync), 1);
        dac_sync[0] = 1'b0;
        repeat (F + 2) tick();
        chk("coinc_pulse", 32'(lose_sync_pulse), 2'b01);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("coinc_cnt", 32'(dac0_cnt_lose_sync), 0);
        chk("coinc_pulse_end", 32'(lose_sync_pulse), 0);
        tick();
        dac_sync[0] = 1'b1;
        wait_link(2'b11, 30, "relock_c");

        // adda_ready dropped mid-lock, then re-raised.
        lose_lane0(p);
        chk("pre_drop_cnt", 32'(dac0_cnt_lose_sync), 1);
        adda_ready = 1'b0;
        repeat (3) tick();
        chk("rdy_drop_link", 32'(link_up), 0);
        chk("rdy_drop_all", 32'(all_link_up), 0);
        chk("rdy_drop_cnt", 32'(dac0_cnt_lose_sync), 1);
        dac_sync[0] = 1'b0;
        total = 0;
        repeat (10) begin
            tick();
            if (lose_sync_pulse !== 2'b00) total++;
        end
        chk("idle_no_pulse", 32'(total), 0);
        chk("idle_cnt_held", 32'(dac0_cnt_lose_sync), 1);
        dac_sync[0] = 1'b1;
        adda_ready = 1'b1;
        repeat (2) tick();
        chk("rise_pre_clr", 32'(dac0_cnt_lose_sync), 1);
        tick();
        chk("rise_clr", 32'(dac0_cnt_lose_sync), 0);
        wait_link(2'b11, 20, "relock_session");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
